lcd_line_prefetch: RTL and testbench
====================================

Name: lcd_line_prefetch

Overview:
Upstream feeder for the LCD RGB top level. It fetches the current frame's RGB565 pixels from the frame-buffer read port in bursts and holds them in a local FIFO. On each `data_req` from the LCD driver it returns one pixel, one cycle later. It re-synchronises to the frame on every `out_vsync` edge.

Parameters:
- DATA_W, 16, pixel/memory word width (RGB565).
- ADDR_W, 24, frame-buffer word-address width.
- FIFO_DEPTH, 64, local FIFO depth in words; power of 2, at least 2*BURST_LEN.
- BURST_LEN, 16, maximum words per read burst; power of 2, at most FIFO_DEPTH/2.

Ports:
- sys_clk, in, 1, LCD pixel clock (same clock as lcd_clk); all logic on rising edge.
- sys_rst, in, 1, asynchronous, active-high reset.
- frame_base, in, ADDR_W, word address of pixel (0,0); sampled at frame start.
- h_disp, in, 11, horizontal resolution from the LCD top.
- v_disp, in, 11, vertical resolution from the LCD top.
- out_vsync, in, 1, LCD field signal; rising edge marks frame start.
- data_req, in, 1, LCD driver pixel request.
- pix_data, out, DATA_W, pixel to the LCD top data_in.
- rd_req, out, 1, burst read request; held until accepted.
- rd_addr, out, ADDR_W, burst start address; valid while rd_req is high.
- rd_len, out, 8, burst length in words (1..BURST_LEN); valid while rd_req is high.
- rd_ack, in, 1, request accepted when rd_req and rd_ack are both high.
- rd_valid, in, 1, read data beat valid.
- rd_data, in, DATA_W, read data beat.
- underflow, out, 1, sticky: data_req arrived with the FIFO empty; cleared at frame start.

Behaviour:
- Reset values: pix_data=0, rd_req=0, rd_addr=0, rd_len=0, underflow=0; FIFO empty; FSM in IDLE. Reset may assert mid-burst; on release, beats of the aborted burst must not reach the FIFO because FSM=IDLE discards rd_valid.
- Frame start:
  - Detected by registering out_vsync and flagging old=0, new=1.
  - Next cycle: flush the FIFO (pointers to 0, count 0).
  - addr <= frame_base.
  - remaining <= h_disp*v_disp (22-bit unsigned product; 0 when either input is 0).
  - Clear underflow.
  - FSM goes to REQ from any state, including WAIT_DATA. Beats still arriving from an abandoned burst are dropped until that burst's beat count is exhausted (DRAIN state).
- FSM states: IDLE, REQ, WAIT_DATA, DRAIN.
  - IDLE: wait for frame start.
  - REQ:
    - If remaining==0, go to IDLE.
    - Else if free = FIFO_DEPTH - count >= BURST_LEN, drive rd_req=1, rd_addr=addr, rd_len=min(BURST_LEN, remaining).
    - On rd_ack: beats_left <= rd_len, addr += rd_len (wraps modulo 2^ADDR_W), remaining -= rd_len; go to WAIT_DATA.
  - WAIT_DATA:
    - Each rd_valid writes rd_data into the FIFO and decrements beats_left.
    - The last beat returns the FSM to REQ.
    - Only one burst is outstanding; the free-space check guarantees no FIFO overflow.
  - DRAIN: count and drop beats until beats_left==0, then go to REQ. Entered only when frame start cuts a burst short; any pending new request waits until the drain completes.
- Pixel output:
  - data_req in cycle N pops the FIFO; the word appears on pix_data in cycle N+1 and is held until the next pop.
  - If the FIFO is empty: pix_data <= 0 in N+1 and underflow <= 1.
- Simultaneous push and pop in one cycle: count is unchanged; both pointers advance.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
- Extra data_req beyond the frame's pixel count behaves as underflow (outputs 0).
- Frame start coinciding with data_req: the flush wins, the pop is ignored, and pix_data <= 0.

Decomposition:
- Shared package lcd_pkg holds:
  - DATA_W and the RGB565 field positions.
  - The 11-bit resolution width.
  - The FSM state encoding as localparams.
- Sub-module: sync_fifo (single-clock, parameterised DATA_W/DEPTH, show-ahead off, with a count output).
- The top keeps the FSM, the address/remaining counters, and the vsync edge detection.

Test Plan:
- Nominal 480x272 frame, frame_base=0x001000, memory acks immediately, data arrives 1 beat/cycle -> bursts at 0x001000, 0x001010, …, total 130560 words. pix_data sequence equals memory contents. underflow stays 0.
- h_disp=5, v_disp=3 (15 pixels), BURST_LEN=16 -> one burst with rd_len=15. A 16th data_req -> pix_data=0 and underflow=1.
- Memory stalls rd_ack for 200 cycles while data_req runs continuously -> FIFO drains, pix_data=0 during the empty phase, underflow=1. Recovery follows once acks resume; underflow clears at the next frame start.
- out_vsync rising edge after beat 6 of a 16-beat burst -> remaining 10 beats dropped (DRAIN). Next rd_req has rd_addr=frame_base. The first pix_data after the edge equals mem[frame_base].
- sys_rst pulsed mid-WAIT_DATA -> all outputs 0 at once (asynchronous). No beats written after release. The fetch sequence restarts correctly at the next vsync edge.
- frame_base=0xFFFFF8, BURST_LEN=16 -> second burst rd_addr wraps to 0x000008.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and fetch FSM encoding for the LCD line prefetcher.
// RGB565 field positions and the 11-bit resolution width live here.
package lcd_pkg;

  localparam int DATA_W = 16;
  localparam int RES_W  = 11;
  localparam int CNT_W  = 2 * RES_W;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = S_IDLE,
    REQ       = S_REQ,
    WAIT_DATA = S_WAIT,
    DRAIN     = S_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered read port, synchronous flush.
// A read of an empty (or flushing) FIFO returns zero.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign empty = (count == '0);
  assign do_wr = wr_en & ~clr & (count != FULL_CNT);
  assign do_rd = rd_en & ~clr & ~empty;

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // registered read word, held until the next read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= do_rd ? mem[rd_ptr] : '0;
    end
  end

endmodule

// File: rtl/lcd_line_prefetch.sv
// Burst prefetcher from the frame buffer into a local pixel FIFO.
// Re-synchronises on every rising edge of out_vsync.
module lcd_line_prefetch #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 24,
  parameter int FIFO_DEPTH = 64,
  parameter int BURST_LEN  = 16
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [ADDR_W-1:0]         frame_base,
  input  logic [lcd_pkg::RES_W-1:0] h_disp,
  input  logic [lcd_pkg::RES_W-1:0] v_disp,
  input  logic                      out_vsync,
  input  logic                      data_req,
  output logic [DATA_W-1:0]         pix_data,
  output logic                      rd_req,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic [7:0]                rd_len,
  input  logic                      rd_ack,
  input  logic                      rd_valid,
  input  logic [DATA_W-1:0]         rd_data,
  output logic                      underflow
);

  import lcd_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      BURST_CNT = (AW+1)'(BURST_LEN);
  localparam logic [CNT_W-1:0] BURST_REM = CNT_W'(BURST_LEN);

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic             vs_q;
  logic             frame_start;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0] remaining_q;
  logic [7:0]       beats_q;
  logic [7:0]       beats_after;
  logic [7:0]       burst_len;
  logic [AW:0]      fifo_count;
  logic [AW:0]      free_words;
  logic             fifo_empty;
  logic             push;
  logic             accept;
  logic             beat_in;
  logic             busy;

  assign frame_start = out_vsync & ~vs_q;
  assign free_words  = DEPTH_CNT - fifo_count;
  assign burst_len   = (remaining_q >= BURST_REM) ?
                       8'(BURST_LEN) : remaining_q[7:0];
  assign busy        = (state_q == WAIT_DATA) | (state_q == DRAIN);
  assign beat_in     = rd_valid & busy;
  assign beats_after = beats_q - {7'd0, beat_in};
  assign accept      = rd_req & rd_ack;

  // vsync edge history
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) vs_q <= 1'b0;
    else         vs_q <= out_vsync;
  end

  // fetch FSM state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next state, request outputs and FIFO push
  always_comb begin
    state_d = state_q;
    rd_req  = 1'b0;
    rd_addr = '0;
    rd_len  = '0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      REQ: begin
        if (remaining_q == '0) begin
          state_d = IDLE;
        end else if (free_words >= BURST_CNT) begin
          rd_req  = 1'b1;
          rd_addr = addr_q;
          rd_len  = burst_len;
          if (rd_ack) state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (rd_valid) begin
          push = 1'b1;
          if (beats_q == 8'd1) state_d = REQ;
        end
      end
      DRAIN: begin
        if (rd_valid && beats_q == 8'd1) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    // a new frame drops in-flight beats, draining any still owed
    if (frame_start) begin
      push = 1'b0;
      if (accept)
        state_d = DRAIN;
      else if (busy && beats_after != 8'd0)
        state_d = DRAIN;
      else
        state_d = REQ;
    end
  end

  // burst address, remaining words and beat counter
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
    end else begin
      if (accept)       beats_q <= rd_len;
      else if (beat_in) beats_q <= beats_after;
      if (frame_start) begin
        addr_q      <= frame_base;
        remaining_q <= CNT_W'(h_disp) * CNT_W'(v_disp);
      end else if (accept) begin
        addr_q      <= addr_q + ADDR_W'(rd_len);
        remaining_q <= remaining_q - CNT_W'(rd_len);
      end
    end
  end

  // sticky underflow, cleared per frame
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                     underflow <= 1'b0;
    else if (frame_start)            underflow <= 1'b0;
    else if (data_req && fifo_empty) underflow <= 1'b1;
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .clr     (frame_start),
    .wr_en   (push),
    .wr_data (rd_data),
    .rd_en   (data_req),
    .rd_data (pix_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_lcd_line_prefetch.sv
// Directed bench for lcd_line_prefetch with a behavioural memory.
// Memory word at address a is a[15:0]^{a[23:16],8'h00}^16'h5A3C.
module tb_lcd_line_prefetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [23:0] frame_base;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic        out_vsync;
  logic        data_req;
  logic [15:0] pix_data;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        underflow;

  logic        ack_en;
  int          total = 0;
  int          bad = 0;
  int          beats_seen = 0;
  logic [23:0] req_addr[$];
  logic [7:0]  req_len[$];
  logic [23:0] beat_q[$];

  always #5 sys_clk = ~sys_clk;

  assign rd_ack = rd_req & ack_en;

  lcd_line_prefetch dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .frame_base (frame_base),
    .h_disp     (h_disp),
    .v_disp     (v_disp),
    .out_vsync  (out_vsync),
    .data_req   (data_req),
    .pix_data   (pix_data),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_len     (rd_len),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .underflow  (underflow)
  );

  function automatic logic [15:0] memf(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], 8'h00} ^ 16'h5A3C;
  endfunction

  // memory: log accepted bursts, queue their beat addresses
  always @(posedge sys_clk) begin
    if (rd_valid) beats_seen++;
    if (rd_req && rd_ack) begin
      req_addr.push_back(rd_addr);
      req_len.push_back(rd_len);
      for (int i = 0; i < int'(rd_len); i++)
        beat_q.push_back(rd_addr + 24'(i));
    end
  end

  // memory: one beat per cycle
  always @(negedge sys_clk) begin
    if (beat_q.size() > 0) begin
      rd_valid = 1'b1;
      rd_data  = memf(beat_q.pop_front());
    end else begin
      rd_valid = 1'b0;
      rd_data  = '0;
    end
  end

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input string nm, input logic [15:0] exp);
    data_req = 1'b1;
    tick();
    data_req = 1'b0;
    chk(nm, pix_data, exp);
  endtask

  task automatic frame_start(input logic [23:0] b, input logic [10:0] h,
                             input logic [10:0] v, input logic pop,
                             input logic ack);
    ack_en     = 1'b0;
    frame_base = b;
    h_disp     = h;
    v_disp     = v;
    out_vsync  = 1'b1;
    data_req   = pop;
    req_addr.delete();
    req_len.delete();
    beats_seen = 0;
    tick();
    data_req = 1'b0;
    ack_en   = ack;
    if (pop) chk("fs_pop_pix", pix_data, 0);
    tick();
    out_vsync = 1'b0;
  endtask

  task automatic quiesce();
    ack_en = 1'b0;
    repeat (30) tick();
  endtask

  typedef struct {
    logic [23:0] base;
    logic [10:0] h;
    logic [10:0] v;
    int          prefill;
    int          npop;
    int          nlog;
    logic [23:0] a0;
    logic [7:0]  l0;
    logic [23:0] a1;
    logic [7:0]  l1;
    logic        uf;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{base:24'h001000, h:11'd480, v:11'd272, prefill:100,
              npop:200, nlog:-1, a0:24'h001000, l0:8'd16,
              a1:24'h001010, l1:8'd16, uf:1'b0};
    vt[1] = '{base:24'h000200, h:11'd5, v:11'd3, prefill:40,
              npop:16, nlog:1, a0:24'h000200, l0:8'd15,
              a1:24'h0, l1:8'd0, uf:1'b1};
    vt[2] = '{base:24'hFFFFF8, h:11'd8, v:11'd4, prefill:60,
              npop:32, nlog:2, a0:24'hFFFFF8, l0:8'd16,
              a1:24'h000008, l1:8'd16, uf:1'b0};
    vt[3] = '{base:24'h0ABC00, h:11'd3, v:11'd7, prefill:60,
              npop:22, nlog:2, a0:24'h0ABC00, l0:8'd16,
              a1:24'h0ABC10, l1:8'd5, uf:1'b1};
    vt[4] = '{base:24'h000300, h:11'd0, v:11'd16, prefill:20,
              npop:2, nlog:0, a0:24'h0, l0:8'd0,
              a1:24'h0, l1:8'd0, uf:1'b1};

    sys_rst    = 1'b1;
    frame_base = '0;
    h_disp     = '0;
    v_disp     = '0;
    out_vsync  = 1'b0;
    data_req   = 1'b0;
    ack_en     = 1'b1;
    repeat (2) tick();
    chk("rst_pix", pix_data, 0);
    chk("rst_req", rd_req, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_len", rd_len, 0);
    chk("rst_uf", underflow, 0);
    sys_rst = 1'b0;
    tick();

    for (int k = 0; k < 5; k++) begin
      logic [21:0] npix;
      npix = 22'(vt[k].h) * 22'(vt[k].v);
      frame_start(vt[k].base, vt[k].h, vt[k].v, 1'b0, 1'b1);
      repeat (vt[k].prefill) tick();
      data_req = 1'b1;
      for (int i = 0; i < vt[k].npop; i++) begin
        tick();
        chk($sformatf("v%0d_pix%0d", k, i), pix_data,
            (i < int'(npix)) ? memf(vt[k].base + 24'(i)) : 16'h0);
      end
      data_req = 1'b0;
      chk($sformatf("v%0d_uf", k), underflow, vt[k].uf);
      if (vt[k].nlog >= 0)
        chk($sformatf("v%0d_nreq", k), req_addr.size(), vt[k].nlog);
      else
        chk($sformatf("v%0d_nreq_min", k), req_addr.size() >= 2, 1);
      if (vt[k].nlog != 0) begin
        chk($sformatf("v%0d_a0", k),
            req_addr.size() > 0 ? req_addr[0] : 24'hBADBAD, vt[k].a0);
        chk($sformatf("v%0d_l0", k),
            req_len.size() > 0 ? req_len[0] : 8'hEE, vt[k].l0);
      end
      if (vt[k].nlog > 1 || vt[k].nlog < 0) begin
        chk($sformatf("v%0d_a1", k),
            req_addr.size() > 1 ? req_addr[1] : 24'hBADBAD, vt[k].a1);
        chk($sformatf("v%0d_l1", k),
            req_len.size() > 1 ? req_len[1] : 8'hEE, vt[k].l1);
      end
      tick();
    end

    // memory stalls acks while the LCD keeps pulling pixels
    frame_start(24'h002000, 11'd480, 11'd272, 1'b0, 1'b1);
    repeat (120) tick();
    ack_en   = 1'b0;
    data_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      chk($sformatf("stall_pix%0d", i), pix_data,
          (i < 64) ? memf(24'h002000 + 24'(i)) : 16'h0);
    end
    data_req = 1'b0;
    chk("stall_uf", underflow, 1);
    ack_en = 1'b1;
    repeat (60) tick();
    pop_chk("stall_recover", memf(24'h002040));
    chk("stall_uf_sticky", underflow, 1);
    frame_start(24'h002000, 11'd480, 11'd272, 1'b0, 1'b1);
    chk("stall_uf_clear", underflow, 0);

    // frame start in the middle of a burst
    quiesce();
    frame_start(24'h004000, 11'd480, 11'd272, 1'b0, 1'b1);
    begin
      int g = 0;
      while (beats_seen < 6 && g < 100) begin
        tick();
        g++;
      end
      chk("drain_wait", g < 100, 1);
    end
    frame_start(24'h008000, 11'd480, 11'd272, 1'b0, 1'b1);
    repeat (60) tick();
    chk("drain_a0",
        req_addr.size() > 0 ? req_addr[0] : 24'hBADBAD, 24'h008000);
    chk("drain_l0", req_len.size() > 0 ? req_len[0] : 8'hEE, 16);
    data_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("drain_pix%0d", i), pix_data,
          memf(24'h008000 + 24'(i)));
    end
    data_req = 1'b0;

    // asynchronous reset while a burst is in flight
    quiesce();
    frame_start(24'h006000, 11'd8, 11'd8, 1'b0, 1'b0);
    pop_chk("rst_t_empty_pix", 16'h0);
    chk("rst_t_uf_set", underflow, 1);
    ack_en = 1'b1;
    begin
      int g = 0;
      while (beats_seen < 4 && g < 100) begin
        tick();
        g++;
      end
      chk("rst_t_wait", g < 100, 1);
    end
    pop_chk("rst_t_pix0", memf(24'h006000));
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_pix", pix_data, 0);
    chk("arst_req", rd_req, 0);
    chk("arst_addr", rd_addr, 0);
    chk("arst_len", rd_len, 0);
    chk("arst_uf", underflow, 0);
    repeat (2) tick();
    sys_rst = 1'b0;
    repeat (20) tick();
    pop_chk("post_rst_pix", 16'h0);
    chk("post_rst_uf", underflow, 1);
    chk("post_rst_req", rd_req, 0);
    frame_start(24'h006000, 11'd8, 11'd8, 1'b0, 1'b1);
    repeat (40) tick();
    chk("restart_a0",
        req_addr.size() > 0 ? req_addr[0] : 24'hBADBAD, 24'h006000);
    pop_chk("restart_pix", memf(24'h006000));

    // frame start coincides with a pixel request
    frame_start(24'h007000, 11'd8, 11'd8, 1'b1, 1'b1);
    chk("coinc_uf", underflow, 0);
    repeat (40) tick();
    pop_chk("coinc_pix", memf(24'h007000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
